// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M-style multiply/divide unit. One request is accepted at a
//   time with a valid/ready handshake; the radix-2 datapath then runs for
//   DATA_WIDTH cycles and the result is held until the consumer takes it.
//   Divide-by-zero, signed overflow and (when the divider is not built)
//   divide-class ops finish on the accepting edge without iterating.
//
// Configuration
//   MULDIV_DIV_EN  define to build the divider datapath (ops 4..7). When it is
//                  undefined, ops 4..7 return 0 with unsupported = 1.
//   DATA_WIDTH     defaults to the `DATA_WIDTH macro (32 if not defined);
//                  legal values 8..64, even.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     request present
//   in_ready     unit is idle and can accept a request
//   op           funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a, b         multiplicand/dividend, multiplier/divisor
//   out_valid    result present
//   out_ready    consumer accepts result
//   result       operation result, held until consumed
//   unsupported  result came from a divide-class op that is not built
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module muldiv_unit #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  unsupported
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [W-1:0]    result_r;
    logic            unsupported_r;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      op_r;
    logic            neg_r;        // final value must be negated
    logic [2*W-1:0]  acc_r;        // {hi, lo}: product, or {remainder, quotient}
    logic [W-1:0]    opnd_r;       // multiplicand or divisor magnitude

    // request-side decode
    logic            a_signed_s;
    logic            b_signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [W-1:0]    a_mag_s;
    logic [W-1:0]    b_mag_s;
    logic            neg_s;
    logic            early_s;
    logic [W-1:0]    early_res_s;
    logic            early_uns_s;

    // iteration datapath
    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_next_s;
    logic [2*W-1:0]  step_next_s;
    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    mul_res_s;
    logic [W-1:0]    final_s;

`ifdef MULDIV_DIV_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    logic [W:0]      div_shift_s;
    logic [W:0]      div_diff_s;
    logic [2*W-1:0]  div_next_s;
    logic [W-1:0]    div_sel_s;
    logic [W-1:0]    div_res_s;
`endif

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign unsupported = unsupported_r;

    // Sign handling, magnitudes and early-exit decode of the request on the inputs
    always_comb begin
        a_signed_s = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed_s = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg_s    = a_signed_s && a[W-1];
        b_neg_s    = b_signed_s && b[W-1];
        // the most-negative value maps onto itself, which is the correct unsigned magnitude
        if (a_neg_s) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
        // remainder takes the dividend's sign; products and quotients the xor
        if (op[2] && op[1]) begin
            neg_s = a_neg_s;
        end else begin
            neg_s = a_neg_s ^ b_neg_s;
        end
`ifdef MULDIV_DIV_EN
        early_uns_s = 1'b0;
        if (op[2] && (b == {W{1'b0}})) begin
            early_s     = 1'b1;
            early_res_s = op[1] ? a : {W{1'b1}};
        end else if (op[2] && !op[0] && (a == MOST_NEG) && (b == {W{1'b1}})) begin
            early_s     = 1'b1;
            early_res_s = op[1] ? {W{1'b0}} : a;
        end else begin
            early_s     = 1'b0;
            early_res_s = {W{1'b0}};
        end
`else
        early_s     = op[2];
        early_res_s = {W{1'b0}};
        early_uns_s = 1'b1;
`endif
    end

    // One radix-2 step of the selected datapath and formatting of the final value
    always_comb begin
        // shift-add: add multiplicand into the high half when the low bit is set, then shift right
        mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[W-1:1]};
        prod_s     = neg_r ? -mul_next_s : mul_next_s;
        mul_res_s  = (op_r == 3'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
`ifdef MULDIV_DIV_EN
        // restoring division: shift next dividend bit into the remainder, keep the difference if it fits
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (!div_diff_s[W]) begin
            div_next_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
        step_next_s = op_r[2] ? div_next_s : mul_next_s;
        div_sel_s   = op_r[1] ? div_next_s[2*W-1:W] : div_next_s[W-1:0];
        div_res_s   = neg_r ? -div_sel_s : div_sel_s;
        final_s     = op_r[2] ? div_res_s : mul_res_s;
`else
        step_next_s = mul_next_s;
        final_s     = mul_res_s;
`endif
    end

    // Control FSM, operand capture, iteration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            result_r      <= {W{1'b0}};
            unsupported_r <= 1'b0;
            cnt_r         <= CNT_ZERO;
            op_r          <= 3'd0;
            neg_r         <= 1'b0;
            acc_r         <= {(2*W){1'b0}};
            opnd_r        <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        neg_r  <= neg_s;
                        cnt_r  <= CNT_ZERO;
                        acc_r  <= {{W{1'b0}}, (op[2] ? a_mag_s : b_mag_s)};
                        opnd_r <= op[2] ? b_mag_s : a_mag_s;
                        in_ready_r <= 1'b0;
                        if (early_s) begin
                            state_r       <= DONE;
                            out_valid_r   <= 1'b1;
                            result_r      <= early_res_s;
                            unsupported_r <= early_uns_s;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    acc_r <= step_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r         <= CNT_ZERO;
                        state_r       <= DONE;
                        out_valid_r   <= 1'b1;
                        result_r      <= final_s;
                        unsupported_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (DATA_WIDTH = 32). The driver computes
//   the expected result, flag and latency of each accepted request from a
//   plain-arithmetic reference model and queues them; an independent monitor
//   pops and compares whenever the unit presents a result, applies random
//   backpressure and checks that held results stay stable. Follows the
//   MULDIV_DIV_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         unsupported;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_res_q[$];
    logic         exp_uns_q[$];
    int           exp_lat_q[$];
    int           acc_q[$];

    bit           holding       = 1'b0;
    bit           leave_pending = 1'b0;
    bit           first_out     = 1'b1;
    logic [W-1:0] hold_res;
    logic         hold_uns;
    int           hold_left     = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .unsupported(unsupported)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_line(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: RV32M semantics from 64-bit products and native int division
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic u, output int lat);
        longint sx, sy, ux, uy, p;
        int     ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        ix = x;
        iy = y;
        u   = 1'b0;
        lat = W + 1;
        r   = 32'd0;
        p   = 64'sd0;
        case (o)
            3'd0: begin p = ux * uy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'd0) begin
                    lat = 1;
                    r   = o[1] ? x : 32'hFFFF_FFFF;
                end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r   = o[1] ? 32'd0 : x;
                end else begin
                    case (o)
                        3'd4:    r = ix / iy;
                        3'd5:    r = x / y;
                        3'd6:    r = ix % iy;
                        default: r = x % y;
                    endcase
                end
`else
                lat = 1;
                u   = 1'b1;
                r   = 32'd0;
`endif
            end
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Junk on the request inputs while the unit is busy; it must be ignored
    task automatic garbage();
        in_valid = ($urandom_range(0, 3) != 0);
        op       = 3'($urandom_range(0, 7));
        a        = $urandom();
        b        = $urandom();
    endtask

    // Present one request at the first idle cycle after a short random gap
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int       gap;
        int       waited;
        bit       done;
        logic [W-1:0] r;
        logic     u;
        int       lat;
        gap    = $urandom_range(0, 2);
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready && gap == 0) begin
                in_valid = 1'b1;
                op       = o;
                a        = x;
                b        = y;
                model(o, x, y, r, u, lat);
                exp_res_q.push_back(r);
                exp_uns_q.push_back(u);
                exp_lat_q.push_back(lat);
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end else begin
                if (in_ready) begin
                    in_valid = 1'b0;
                    gap--;
                end else begin
                    garbage();
                end
                waited++;
                if (waited > 200) begin
                    fail_line("issue_timeout");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
            if (exp_res_q.size() == 0 && !holding && !leave_pending && in_ready) ok = 1'b1;
        end
        if (!ok) fail_line("drain_timeout");
    endtask

    // Monitor: compare each new result, check holds, drive random out_ready
    always @(negedge clk) begin
        logic [W-1:0] r;
        logic         u;
        int           lat;
        int           acc;
        if (leave_pending) begin
            check("done_exit_out_valid", out_valid, 1'b0);
            leave_pending = 1'b0;
            holding       = 1'b0;
        end
        if (out_valid === 1'b1) begin
            check("in_ready_in_done", in_ready, 1'b0);
            if (!holding) begin
                if (exp_res_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: actual result %0h required no output (cycle %0d)", result, cyc);
                end else begin
                    r   = exp_res_q.pop_front();
                    u   = exp_uns_q.pop_front();
                    lat = exp_lat_q.pop_front();
                    acc = acc_q.pop_front();
                    check("result", result, r);
                    check("unsupported", unsupported, u);
                    check("latency", cyc - acc + 1, lat);
                end
                holding   = 1'b1;
                hold_res  = result;
                hold_uns  = unsupported;
                hold_left = first_out ? 10 : $urandom_range(0, 3);
                first_out = 1'b0;
            end else begin
                check("hold_result", result, hold_res);
                check("hold_unsupported", unsupported, hold_uns);
            end
            if (hold_left == 0) begin
                out_ready     = 1'b1;
                leave_pending = 1'b1;
            end else begin
                out_ready = 1'b0;
                hold_left--;
            end
        end else begin
            holding   = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    logic [2:0]   d_op [10] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [W-1:0] d_a  [10] = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000,
                                32'h8000_0000, 32'd9};
    logic [W-1:0] d_b  [10] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0002,
                                32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd0;
        a         = 32'd3;
        b         = 32'd5;
        // reset must win over a request held high throughout it
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 32'd0);
        check("reset_unsupported", unsupported, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i]);
        drain();

        for (int i = 0; i < 150; i++) issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        issue(3'd0, 32'd3, 32'd5);
        drain();

        // abort a multiply at its 15th iteration
        in_valid = 1'b1;
        op       = 3'd0;
        a        = $urandom();
        b        = $urandom();
        @(negedge clk);
        in_valid = 1'b0;
        check("calc_in_ready", in_ready, 1'b0);
        repeat (14) @(negedge clk);
        check("calc_result_retained", result, 32'd15);
        check("calc_out_valid", out_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, 32'd0);
        check("abort_unsupported", unsupported, 1'b0);

        issue(3'd5, 32'd100, 32'd7);
        drain();
        check("queue_empty", exp_res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
